rob_commit_unit: RTL

- Reorder buffer downstream of the branch-condition unit and of both CDB producers (ALU, MEM).
- Allocates entries in program order from the decoder and collects writebacks from ALU/MEM CDB and BCU.
- Commits one completed entry per cycle to the register file.
- Resolves branch mispredicts at commit by asserting flush and a redirect PC to the fetch unit.

---
 rtl/rob_commit_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocates entries in program order, collects ALU/MEM/BCU
// writebacks, retires one completed entry per cycle and turns a mispredicted
// branch into a flush with a redirect PC at its commit edge.
module rob_commit_unit #(
  parameter int ROB_SIZE = 8,
  parameter int ID_WIDTH = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                alloc_en,
  input  logic                alloc_is_branch,
  input  logic                alloc_pred_taken,
  input  logic [4:0]          alloc_rd,
  output logic [ID_WIDTH-1:0] alloc_id,
  output logic                full,
  output logic                one_left,
  input  logic [ID_WIDTH-1:0] cdb_alu_rob_id,
  input  logic [31:0]         cdb_alu_value,
  input  logic [ID_WIDTH-1:0] cdb_mem_rob_id,
  input  logic [31:0]         cdb_mem_value,
  input  logic [ID_WIDTH-1:0] bcu_rob_id,
  input  logic                bcu_taken,
  input  logic [31:0]         bcu_value,
  input  logic [ID_WIDTH-1:0] query_j_id,
  output logic                query_j_ready,
  output logic [31:0]         query_j_value,
  input  logic [ID_WIDTH-1:0] query_k_id,
  output logic                query_k_ready,
  output logic [31:0]         query_k_value,
  output logic                commit_valid,
  output logic [ID_WIDTH-1:0] commit_rob_id,
  output logic [4:0]          commit_rd,
  output logic [31:0]         commit_value,
  output logic                flush_out,
  output logic [31:0]         redirect_pc
);

  localparam int IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
  localparam int CNT_W = $clog2(ROB_SIZE + 1);

  // Control state (reset)
  logic [IDX_W-1:0]    head_q;
  logic [IDX_W-1:0]    tail_q;
  logic [CNT_W-1:0]    count_q;
  logic [ROB_SIZE-1:0] busy_q;
  logic [ROB_SIZE-1:0] ready_q;

  // Entry payload (no reset; only read while busy/ready say it is valid)
  logic [ROB_SIZE-1:0] is_br_q;
  logic [ROB_SIZE-1:0] pred_q;
  logic [ROB_SIZE-1:0] taken_q;
  logic [4:0]          rd_q    [ROB_SIZE];
  logic [31:0]         value_q [ROB_SIZE];

  // Id 0 is "none"; ids above ROB_SIZE never name an entry.
  function automatic logic id_ok(input logic [ID_WIDTH-1:0] id);
    return (id != '0) && (id <= ID_WIDTH'(ROB_SIZE));
  endfunction

  function automatic logic [IDX_W-1:0] id2idx(input logic [ID_WIDTH-1:0] id);
    return IDX_W'(id - ID_WIDTH'(1));
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(ROB_SIZE - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  logic [IDX_W-1:0] alu_idx, mem_idx, bcu_idx;
  logic             alu_hit, mem_hit, bcu_hit;
  logic             alloc_fire, commit_fire, mispredict;

  assign alu_idx = id2idx(cdb_alu_rob_id);
  assign mem_idx = id2idx(cdb_mem_rob_id);
  assign bcu_idx = id2idx(bcu_rob_id);
  assign alu_hit = id_ok(cdb_alu_rob_id) && busy_q[alu_idx];
  assign mem_hit = id_ok(cdb_mem_rob_id) && busy_q[mem_idx];
  assign bcu_hit = id_ok(bcu_rob_id)     && busy_q[bcu_idx];

  assign full     = (count_q == CNT_W'(ROB_SIZE));
  assign one_left = (count_q == CNT_W'(ROB_SIZE - 1));
  assign alloc_id = ID_WIDTH'(tail_q) + ID_WIDTH'(1);

  // Head readiness is the registered state, so a writeback to the head
  // always costs one cycle before that entry can retire.
  assign alloc_fire  = alloc_en && !full;
  assign commit_fire = busy_q[head_q] && ready_q[head_q];
  assign mispredict  = commit_fire && is_br_q[head_q] &&
                       (taken_q[head_q] != pred_q[head_q]);

  // Operand lookup: stored value first, then same-cycle CDB bypass (ALU first).
  function automatic logic [32:0] lookup(input logic [ID_WIDTH-1:0] id);
    logic [IDX_W-1:0] idx;
    idx = id2idx(id);
    if (id == '0)
      return {1'b1, 32'd0};
    if (!id_ok(id) || !busy_q[idx])
      return 33'd0;
    if (ready_q[idx])
      return {1'b1, value_q[idx]};
    if (id == cdb_alu_rob_id)
      return {1'b1, cdb_alu_value};
    if (id == cdb_mem_rob_id)
      return {1'b1, cdb_mem_value};
    return 33'd0;
  endfunction

  assign {query_j_ready, query_j_value} = lookup(query_j_id);
  assign {query_k_ready, query_k_value} = lookup(query_k_id);

  // Pointers, occupancy, completion flags and the registered commit/flush outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      busy_q        <= '0;
      ready_q       <= '0;
      commit_valid  <= 1'b0;
      commit_rob_id <= '0;
      commit_rd     <= '0;
      commit_value  <= '0;
      flush_out     <= 1'b0;
      redirect_pc   <= '0;
    end else begin
      commit_valid <= 1'b0;
      flush_out    <= 1'b0;
      redirect_pc  <= '0;
      if (alloc_fire) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        tail_q          <= idx_inc(tail_q);
      end
      if (bcu_hit) ready_q[bcu_idx] <= 1'b1;
      if (mem_hit) ready_q[mem_idx] <= 1'b1;
      if (alu_hit) ready_q[alu_idx] <= 1'b1;
      count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
      if (commit_fire) begin
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
        head_q          <= idx_inc(head_q);
        commit_valid    <= 1'b1;
        commit_rob_id   <= ID_WIDTH'(head_q) + ID_WIDTH'(1);
        commit_rd       <= is_br_q[head_q] ? 5'd0 : rd_q[head_q];
        commit_value    <= value_q[head_q];
        // Mispredict wipes every younger entry, including this cycle's allocation.
        if (mispredict) begin
          busy_q      <= '0;
          ready_q     <= '0;
          head_q      <= '0;
          tail_q      <= '0;
          count_q     <= '0;
          flush_out   <= 1'b1;
          redirect_pc <= value_q[head_q];
        end
      end
    end
  end

  // Entry payload capture; ALU is written last so it wins over MEM on the same id
  always_ff @(posedge clk_in) begin
    if (alloc_fire) begin
      rd_q[tail_q]    <= alloc_rd;
      is_br_q[tail_q] <= alloc_is_branch;
      pred_q[tail_q]  <= alloc_pred_taken;
    end
    if (bcu_hit) begin
      value_q[bcu_idx] <= bcu_value;
      taken_q[bcu_idx] <= bcu_taken;
    end
    if (mem_hit) value_q[mem_idx] <= cdb_mem_value;
    if (alu_hit) value_q[alu_idx] <= cdb_alu_value;
  end

endmodule
